// File: rtl/dm_lsu_if.sv
// CPU-side request/response handshake plus the data-memory initiator bus
// of the load/store unit, bundled so the LSU and its neighbours share one
// port list.
interface dm_lsu_if;
    // CPU request
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    // CPU response
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    // data memory
    logic        dm_ce;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;

    // LSU side
    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  dm_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output dm_ce, dm_we, dm_addr, dm_wdata
    );

    // CPU + memory side (the environment driving the LSU)
    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output dm_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  dm_ce, dm_we, dm_addr, dm_wdata
    );
endinterface

// File: rtl/dm_lsu.sv
// Load/store unit: one request at a time toward a byte-addressed,
// little-endian data memory. Word stores write directly, byte/half stores
// do read-modify-write, loads read one word and extend the requested part.
// All outputs are registered; they are set on the edge that enters a state.
module dm_lsu #(
    parameter int MEM_AW = 8    // valid address bits, 1..31
) (
    input  logic     clk,
    input  logic     rst_n,
    dm_lsu_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t      r_state;
    // latched request
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_uns;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    // registered outputs
    logic        r_req_ready;
    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic        r_resp_err;
    logic        r_dm_ce;
    logic        r_dm_we;
    logic [31:0] r_dm_addr;
    logic [31:0] r_dm_wdata;

    logic        w_req_err;
    logic [31:0] w_merge;
    logic [31:0] w_load;

    // Illegal size or any address bit above the memory window set.
    assign w_req_err = (bus.req_size == 2'b11) || (bus.req_addr[31:MEM_AW] != '0);

    // The RD-cycle read word is consumed at the end of RD: merged with the
    // store data for the following WR, or extended into the load result.
    // Splice store data into the word read during RD
    always_comb begin
        case (r_size)
            2'b00:   w_merge = {bus.dm_rdata[31:8],  r_wdata[7:0]};
            2'b01:   w_merge = {bus.dm_rdata[31:16], r_wdata[15:0]};
            default: w_merge = r_wdata;
        endcase
    end

    // Extract and sign/zero-extend the load result from the RD-cycle word
    always_comb begin
        case (r_size)
            2'b00:   w_load = {{24{~r_uns & bus.dm_rdata[7]}},  bus.dm_rdata[7:0]};
            2'b01:   w_load = {{16{~r_uns & bus.dm_rdata[15]}}, bus.dm_rdata[15:0]};
            default: w_load = bus.dm_rdata;
        endcase
    end

    // Request sequencer; reset kills any in-flight access before it writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_we         <= 1'b0;
            r_size       <= 2'b00;
            r_uns        <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
            r_dm_ce      <= 1'b0;
            r_dm_we      <= 1'b0;
            r_dm_addr    <= '0;
            r_dm_wdata   <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_we        <= bus.req_we;
                        r_size      <= bus.req_size;
                        r_uns       <= bus.req_unsigned;
                        r_addr      <= bus.req_addr;
                        r_wdata     <= bus.req_wdata;
                        r_req_ready <= 1'b0;
                        if (w_req_err) begin
                            // memory is never enabled for a rejected request
                            r_state      <= RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= '0;
                        end else if (bus.req_we && bus.req_size == 2'b10) begin
                            r_state    <= WR;
                            r_dm_ce    <= 1'b1;
                            r_dm_we    <= 1'b1;
                            r_dm_addr  <= bus.req_addr;
                            r_dm_wdata <= bus.req_wdata;
                        end else begin
                            r_state   <= RD;
                            r_dm_ce   <= 1'b1;
                            r_dm_we   <= 1'b0;
                            r_dm_addr <= bus.req_addr;
                        end
                    end
                end
                RD: begin
                    if (r_we) begin
                        r_state    <= WR;
                        r_dm_we    <= 1'b1;
                        r_dm_addr  <= r_addr;
                        r_dm_wdata <= w_merge;
                    end else begin
                        r_state      <= RESP;
                        r_dm_ce      <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= w_load;
                    end
                end
                WR: begin
                    r_state      <= RESP;
                    r_dm_ce      <= 1'b0;
                    r_dm_we      <= 1'b0;
                    r_resp_valid <= 1'b1;
                    r_resp_rdata <= '0;
                end
                RESP: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b1;
                end
                default: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b1;
                    r_dm_ce     <= 1'b0;
                    r_dm_we     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.resp_err   = r_resp_err;
    assign bus.dm_ce      = r_dm_ce;
    assign bus.dm_we      = r_dm_we;
    assign bus.dm_addr    = r_dm_addr;
    assign bus.dm_wdata   = r_dm_wdata;

endmodule

// File: tb/tb_dm_lsu.sv
// Bench for dm_lsu: a 256-byte memory model on the dm_* side, directed
// vector table, reset/back-to-back sequences and random traffic checked
// against a byte-array reference model.
module tb_dm_lsu;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dm_lsu_if bus();

    dm_lsu #(.MEM_AW(8)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errs = 0;
    int checks = 0;

    // ---------------- memory model ----------------
    logic [7:0]  mem [256];
    logic [7:0]  ma;
    logic        poke = 1'b0;
    logic [7:0]  poke_a = '0;
    logic [7:0]  poke_d = '0;

    assign ma = bus.dm_addr[7:0];
    assign bus.dm_rdata = bus.dm_ce ? {mem[8'(ma + 8'd3)], mem[8'(ma + 8'd2)],
                                       mem[8'(ma + 8'd1)], mem[ma]} : 32'hDEADBEEF;

    always @(posedge clk) begin
        if (poke) mem[poke_a] <= poke_d;
        else if (bus.dm_ce && bus.dm_we)
            for (int k = 0; k < 4; k++) mem[8'(ma + 8'(k))] <= bus.dm_wdata[8*k +: 8];
    end

    // ---------------- reference model ----------------
    logic [7:0] ref_mem [256];

    task automatic ref_op(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic err, output int lat);
        int n;
        rd  = '0;
        err = (sz == 2'd3) || (a >= 32'd256);
        if (err) begin lat = 1; return; end
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        if (we) begin
            for (int k = 0; k < n; k++) ref_mem[(a + k) % 256] = wd[8*k +: 8];
            lat = (n == 4) ? 2 : 3;
        end else begin
            for (int k = 0; k < n; k++) rd[8*k +: 8] = ref_mem[(a + k) % 256];
            if (!uns && n < 4 && rd[8*n-1]) rd = rd | ~((32'd1 << (8*n)) - 32'd1);
            lat = 2;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic poke_byte(input logic [7:0] a, input logic [7:0] d);
        poke = 1'b1; poke_a = a; poke_d = d;
        @(posedge clk); #1;
        poke = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic poke_word(input logic [7:0] a, input logic [31:0] d);
        for (int k = 0; k < 4; k++) poke_byte(8'(a + 8'(k)), d[8*k +: 8]);
    endtask

    // One request; returns response, latency and what was seen on the bus.
    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic err, output int lat,
                          output logic saw_ce, output logic [31:0] wr_data,
                          output logic busy_ready);
        int g = 0;
        while (!bus.req_ready && g < 20) begin @(posedge clk); #1; g++; end
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = sz;
        bus.req_unsigned = uns; bus.req_addr = a; bus.req_wdata = wd;
        @(posedge clk); #1;
        // garbage on req_* while busy must not be picked up
        bus.req_valid = 1'b0; bus.req_we = ~we; bus.req_size = ~sz;
        bus.req_unsigned = ~uns; bus.req_addr = $urandom; bus.req_wdata = $urandom;
        lat = 0; saw_ce = 1'b0; wr_data = 'x; busy_ready = 1'b0;
        forever begin
            lat++;
            if (bus.dm_ce) saw_ce = 1'b1;
            if (bus.dm_we) wr_data = bus.dm_wdata;
            if (bus.req_ready) busy_ready = 1'b1;
            if (bus.resp_valid || lat >= 10) break;
            @(posedge clk); #1;
        end
        rd = bus.resp_rdata; err = bus.resp_err;
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
        logic        chk_wd;
        logic [31:0] exp_wd;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic [31:0] rd, mrd, wdv, w;
        logic        err, merr, saw_ce, busy_rdy;
        int          lat, mlat;

        bus.req_valid = 0; bus.req_we = 0; bus.req_size = 0; bus.req_unsigned = 0;
        bus.req_addr = 0; bus.req_wdata = 0;

        vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h10,  32'h8899AABB, 32'h0,        1'b0, 2, 1'b1, 32'h8899AABB};
        vecs[1]  = '{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'h8899AABB, 1'b0, 2, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 2'd0, 1'b0, 32'h10,  32'h0,        32'hFFFFFFBB, 1'b0, 2, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, 2'd1, 1'b1, 32'h12,  32'h0,        32'h00008899, 1'b0, 2, 1'b0, 32'h0};
        vecs[4]  = '{1'b1, 2'd0, 1'b0, 32'h20,  32'hFFFFFF5A, 32'h0,        1'b0, 3, 1'b1, 32'h1122335A};
        vecs[5]  = '{1'b0, 2'd2, 1'b0, 32'h20,  32'h0,        32'h1122335A, 1'b0, 2, 1'b0, 32'h0};
        vecs[6]  = '{1'b1, 2'd1, 1'b0, 32'h40,  32'h1234BEEF, 32'h0,        1'b0, 3, 1'b1, 32'hCAFEBEEF};
        vecs[7]  = '{1'b0, 2'd2, 1'b0, 32'h40,  32'h0,        32'hCAFEBEEF, 1'b0, 2, 1'b0, 32'h0};
        vecs[8]  = '{1'b0, 2'd1, 1'b0, 32'h40,  32'h0,        32'hFFFFBEEF, 1'b0, 2, 1'b0, 32'h0};
        vecs[9]  = '{1'b0, 2'd2, 1'b0, 32'h100, 32'h0,        32'h0,        1'b1, 1, 1'b0, 32'h0};
        vecs[10] = '{1'b1, 2'd3, 1'b0, 32'h0,   32'h55555555, 32'h0,        1'b1, 1, 1'b0, 32'h0};
        vecs[11] = '{1'b0, 2'd0, 1'b1, 32'h13,  32'h0,        32'h00000088, 1'b0, 2, 1'b0, 32'h0};

        // preload memory while held in reset
        for (int i = 0; i < 256; i++) poke_byte(8'(i), 8'($urandom));
        poke_word(8'h20, 32'h11223344);
        poke_word(8'h40, 32'hCAFED00D);
        poke_word(8'h50, 32'hA0B0C0D0);

        chk("rst_ready",  32'(bus.req_ready),  32'd1);
        chk("rst_rvalid", 32'(bus.resp_valid), 32'd0);
        chk("rst_err",    32'(bus.resp_err),   32'd0);
        chk("rst_rdata",  bus.resp_rdata,      32'd0);
        chk("rst_ce_we",  {30'd0, bus.dm_ce, bus.dm_we}, 32'd0);
        chk("rst_addr",   bus.dm_addr,         32'd0);
        chk("rst_wdata",  bus.dm_wdata,        32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // directed table
        for (int i = 0; i < 12; i++) begin
            do_req(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                   rd, err, lat, saw_ce, wdv, busy_rdy);
            ref_op(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                   mrd, merr, mlat);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            chk($sformatf("vec%0d_err", i),   32'(err), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d_lat", i),   32'(lat), 32'(vecs[i].exp_lat));
            chk($sformatf("vec%0d_busy_ready", i), 32'(busy_rdy), 32'd0);
            if (vecs[i].exp_err) chk($sformatf("vec%0d_ce_on_err", i), 32'(saw_ce), 32'd0);
            if (vecs[i].chk_wd)  chk($sformatf("vec%0d_wr_data", i), wdv, vecs[i].exp_wd);
        end

        // reset during WR of a byte store: no write may land
        while (!bus.req_ready) begin @(posedge clk); #1; end
        bus.req_valid = 1; bus.req_we = 1; bus.req_size = 2'd0; bus.req_unsigned = 0;
        bus.req_addr = 32'h50; bus.req_wdata = 32'h77;
        @(posedge clk); #1;
        bus.req_valid = 0;
        chk("mid_rd_ce_we", {30'd0, bus.dm_ce, bus.dm_we}, 32'd2);
        @(posedge clk); #1;
        chk("mid_wr_we",    32'(bus.dm_we), 32'd1);
        chk("mid_wr_wdata", bus.dm_wdata,   32'hA0B0C077);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ce_we", {30'd0, bus.dm_ce, bus.dm_we}, 32'd0);
        chk("mid_rst_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk); @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        w = {mem[8'h53], mem[8'h52], mem[8'h51], mem[8'h50]};
        chk("mid_mem_kept",    w, 32'hA0B0C0D0);
        chk("mid_after_ready", 32'(bus.req_ready),  32'd1);
        chk("mid_after_rvalid",32'(bus.resp_valid), 32'd0);
        do_req(1'b0, 2'd2, 1'b0, 32'h50, 32'h0, rd, err, lat, saw_ce, wdv, busy_rdy);
        chk("mid_reload", rd, 32'hA0B0C0D0);

        // back-to-back: req_valid held, fields change to the second request
        bus.req_valid = 1; bus.req_we = 1; bus.req_size = 2'd2; bus.req_unsigned = 0;
        bus.req_addr = 32'h30; bus.req_wdata = 32'h01020304;
        while (!bus.req_ready) begin @(posedge clk); #1; end
        @(posedge clk); #1;
        bus.req_we = 0; bus.req_addr = 32'h30; bus.req_wdata = 32'hFFFFFFFF;
        bus.req_unsigned = 1;
        lat = 0; busy_rdy = 0;
        forever begin
            lat++;
            if (bus.req_ready) busy_rdy = 1'b1;
            if (bus.resp_valid || lat >= 10) break;
            @(posedge clk); #1;
        end
        ref_op(1'b1, 2'd2, 1'b0, 32'h30, 32'h01020304, mrd, merr, mlat);
        chk("b2b_a_lat",   32'(lat), 32'd2);
        chk("b2b_a_busy",  32'(busy_rdy), 32'd0);
        @(posedge clk); #1;
        chk("b2b_idle_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        chk("b2b_b_taken", 32'(bus.req_ready), 32'd0);
        bus.req_valid = 0;
        lat = 1;
        while (!bus.resp_valid && lat < 10) begin @(posedge clk); #1; lat++; end
        ref_op(1'b0, 2'd2, 1'b1, 32'h30, 32'h0, mrd, merr, mlat);
        chk("b2b_b_lat",   32'(lat), 32'd2);
        chk("b2b_b_rdata", bus.resp_rdata, 32'h01020304);

        // random traffic against the reference model
        for (int i = 0; i < 300; i++) begin
            logic        we, uns;
            logic [1:0]  sz;
            logic [31:0] a, wd;
            we  = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            sz  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a   = ($urandom_range(0, 9) == 0) ? ($urandom | 32'h100) : 32'($urandom_range(0, 255));
            wd  = $urandom;
            do_req(we, sz, uns, a, wd, rd, err, lat, saw_ce, wdv, busy_rdy);
            ref_op(we, sz, uns, a, wd, mrd, merr, mlat);
            chk($sformatf("rnd%0d_rdata", i), rd, mrd);
            chk($sformatf("rnd%0d_err", i),   32'(err), 32'(merr));
            chk($sformatf("rnd%0d_lat", i),   32'(lat), 32'(mlat));
            if (merr) chk($sformatf("rnd%0d_ce_on_err", i), 32'(saw_ce), 32'd0);
        end

        @(posedge clk); @(posedge clk); #1;
        begin
            int diffs = 0;
            for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diffs++;
            chk("final_mem_diffs", 32'(diffs), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
